mel_band_accumulator: RTL and testbench
=======================================

# mel_band_accumulator

Accumulates the stream of weighted power-spectrum products leaving the Q-format complex multiplier into per-band mel energies. Sits directly downstream of the multiplier in the mel filter-bank path. The upstream sequencer presents products in band order, with overlapping bins repeated, and marks the last product of each band. The block emits one saturating band sum per band over a valid/ready handshake and tags the final band of each frame.

## Interface
- `WIDTH_IN`, 16: product width, signed, taken from the multiplier real output.
- `Q_IN`, 15: fractional bits of the product. The output keeps the same Q; no rescaling.
- `ACC_WIDTH`, 24: accumulator and output width, signed. Must be ≥ `WIDTH_IN`.
- `NUM_BANDS`, 40: mel bands per frame.
- `BAND_W`, `$clog2(NUM_BANDS)`: band index width.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `di_valid`  in  1  product present.
- `di_data`  in  `WIDTH_IN`  signed product, Q`Q_IN`.
- `di_last`  in  1  last product of the current band.
- `di_ready`  out  1  product accepted when `di_valid & di_ready`.
- `do_valid`  out  1  band sum present.
- `do_data`  out  `ACC_WIDTH`  signed band sum, Q`Q_IN`.
- `do_band`  out  `BAND_W`  band index, 0..`NUM_BANDS`-1.
- `do_frame_last`  out  1  asserted with band `NUM_BANDS`-1.
- `do_ready`  in  1  downstream accepts the band sum.

## Operation
- States: `ACCUM` (`do_valid`=0) and `HOLD` (`do_valid`=1).
- `di_ready = !do_valid | do_ready`. This gives full throughput with a single output register and no skid buffer.
- Accepted product without `di_last`: `acc <= sat(acc + sext(di_data))`.
- Accepted product with `di_last`:
  - `do_data <= sat(acc + sext(di_data))`, `do_band <= band_cnt`, `do_frame_last <= (band_cnt == NUM_BANDS-1)`.
  - `do_valid <= 1`, `acc <= 0`.
  - `band_cnt` increments, wrapping from `NUM_BANDS`-1 to 0.
- `do_valid & do_ready` with no new `di_last` in the same cycle: `do_valid <= 0`.
- If `do_ready` and an accepted `di_last` occur in the same cycle, the new sum replaces the old one and `do_valid` stays 1.
- A band of exactly one product is legal: `di_last` on its first sample gives `do_data = sext(di_data)`.
- Sign-extension only, no shifting. Sums carry `ACC_WIDTH`-`WIDTH_IN` guard bits.
- Outputs `do_data`, `do_band` and `do_frame_last` hold stable while `do_valid & !do_ready`.

## Timing
- Reset values: `acc`=0, `band_cnt`=0, `do_valid`=0, `do_data`=0, `do_band`=0, `do_frame_last`=0. `di_ready` is 1 out of reset (it is combinational).
- Latency: `do_valid` rises 1 cycle after the accepted `di_last`.
- Throughput: 1 product per cycle while `do_ready`=1.
- Reset asserted mid-band discards the partial sum and any held output. The next frame starts at band 0.
- `di_data` is ignored when `di_valid`=0 or `di_ready`=0.

## Configuration
- `MEL_ACC_SAT_EN` defined:
  - `sat()` clamps to [-2^(`ACC_WIDTH`-1), 2^(`ACC_WIDTH`-1)-1].
  - The clamp is applied at every add, so once a band saturates it stays clamped for the rest of that band.
- `MEL_ACC_SAT_EN` undefined: `sat()` is identity and two's-complement wrap applies.

## Structure
- Shared package `mel_pkg`:
  - `MEL_NUM_BANDS`, `MEL_PROD_W`, `MEL_PROD_Q`, `MEL_ACC_W` constants.
  - `mel_band_t` typedef, sized `$clog2(MEL_NUM_BANDS)`.
- One sub-module, `mel_sat_add`: a combinational signed adder with saturation, gated by the macro.
- Counter, FSM and output register live in the top level.

## Test plan
- **Basic band sum:** 3× `di_data`=0x3333, last on the third, `do_ready`=1 → `do_data`=39321 (0x9999), `do_band`=0, `do_valid` one cycle after the last.
- **Saturation, macro on:** `ACC_WIDTH`=24, 300× 32767 in one band → `do_data`=8388607. Repeat with 300× -32768 → -8388608.
- **Saturation, macro off:** 300× 32767 → `do_data`=-6947116 (wrapped).
- **Backpressure:** hold `do_ready`=0 for 5 cycles after a band completes → `di_ready`=0, outputs stable. Release → one handshake, then `di_ready`=1. Products sent while stalled are not lost and not double-counted.
- **Frame wrap:** `NUM_BANDS`=4, 4 single-sample bands (1, 2, 3, 4) then 1 more → `do_band` 0, 1, 2, 3, 0 and `do_frame_last` only on band 3.
- **Reset mid-band:** 2 products of 100, then `reset` for 1 cycle, then 1 product 7 with last → `do_data`=7, `do_band`=0.

Source files
------------

// File: rtl/mel_pkg.sv
// Shared constants and types for the mel filter-bank accumulation path.
package mel_pkg;

  localparam int MEL_NUM_BANDS = 40;
  localparam int MEL_PROD_W    = 16;
  localparam int MEL_PROD_Q    = 15;
  localparam int MEL_ACC_W     = 24;

  typedef logic [$clog2(MEL_NUM_BANDS)-1:0] mel_band_t;

  // ACCUM: summing the current band; HOLD: a finished band sum is waiting downstream.
  typedef enum logic {
    MEL_ACCUM = 1'b0,
    MEL_HOLD  = 1'b1
  } mel_state_t;

endpackage

// File: rtl/mel_sat_add.sv
// Combinational signed adder: acc + sext(b). Clamps to the acc range when
// MEL_ACC_SAT_EN is defined, otherwise wraps in two's complement.
module mel_sat_add #(
  parameter int A_W = 24,
  parameter int B_W = 16
) (
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  output logic signed [A_W-1:0] sum
);

`ifdef MEL_ACC_SAT_EN
  logic signed [A_W:0] wide;

  // One extra bit catches overflow; the top two bits disagree exactly on overflow.
  assign wide = (A_W+1)'(a) + (A_W+1)'(b);

  always_comb begin
    if (wide[A_W] != wide[A_W-1]) begin
      sum = wide[A_W] ? {1'b1, {(A_W-1){1'b0}}} : {1'b0, {(A_W-1){1'b1}}};
    end else begin
      sum = wide[A_W-1:0];
    end
  end
`else
  assign sum = a + A_W'(b);
`endif

endmodule

// File: rtl/mel_band_accumulator.sv
// Sums weighted spectrum products into per-band mel energies, one output per band.
// Saturating accumulation is enabled by defining MEL_ACC_SAT_EN.
module mel_band_accumulator
  import mel_pkg::*;
#(
  parameter int WIDTH_IN  = MEL_PROD_W,
  parameter int Q_IN      = MEL_PROD_Q,
  parameter int ACC_WIDTH = MEL_ACC_W,
  parameter int NUM_BANDS = MEL_NUM_BANDS,
  parameter int BAND_W    = $clog2(NUM_BANDS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        di_valid,
  input  logic signed [WIDTH_IN-1:0]  di_data,
  input  logic                        di_last,
  output logic                        di_ready,
  output logic                        do_valid,
  output logic signed [ACC_WIDTH-1:0] do_data,
  output logic [BAND_W-1:0]           do_band,
  output logic                        do_frame_last,
  input  logic                        do_ready
);

  mel_state_t                  state, state_nxt;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] sum;
  logic [BAND_W-1:0]           band_cnt;
  logic                        accept;
  logic                        band_done;
  logic                        band_wrap;

  // Q_IN only documents the fixed-point format; no rescaling happens here.
  localparam int unsigned Q_OUT = Q_IN;

  // A single output register suffices: new input is taken whenever the slot is free or draining.
  assign di_ready  = !do_valid || do_ready;
  assign accept    = di_valid && di_ready;
  assign band_done = accept && di_last;
  assign band_wrap = (band_cnt == BAND_W'(NUM_BANDS - 1));
  assign do_valid  = (state == MEL_HOLD);

  mel_sat_add #(
    .A_W (ACC_WIDTH),
    .B_W (WIDTH_IN)
  ) u_sat_add (
    .a   (acc),
    .b   (di_data),
    .sum (sum)
  );

  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= MEL_ACCUM;
    else       state <= state_nxt;
  end

  // NOTE: next-state gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      MEL_ACCUM: if (band_done) state_nxt = MEL_HOLD;
      MEL_HOLD:  if (do_ready && !band_done) state_nxt = MEL_ACCUM;
      default:   state_nxt = MEL_ACCUM;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc           <= '0;
      band_cnt      <= '0;
      do_data       <= '0;
      do_band       <= '0;
      do_frame_last <= 1'b0;
    end else if (accept) begin
      if (di_last) begin
        do_data       <= sum;
        do_band       <= band_cnt;
        do_frame_last <= band_wrap;
        acc           <= '0;
        band_cnt      <= band_wrap ? '0 : band_cnt + 1'b1;
      end else begin
        acc <= sum;
      end
    end
  end

endmodule

// File: tb/tb_mel_band_accumulator.sv
// Self-checking bench for mel_band_accumulator (4 bands per frame); the reference
// model follows MEL_ACC_SAT_EN so the bench suits either build.
module tb_mel_band_accumulator;

  localparam int  W_IN = 16;
  localparam int  ACCW = 24;
  localparam int  NB   = 4;
  localparam int  BW   = $clog2(NB);
  localparam longint MAXV = (longint'(1) <<< (ACCW-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (ACCW-1));

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   di_valid = 1'b0;
  logic signed [W_IN-1:0] di_data = '0;
  logic                   di_last = 1'b0;
  logic                   di_ready;
  logic                   do_valid;
  logic signed [ACCW-1:0] do_data;
  logic [BW-1:0]          do_band;
  logic                   do_frame_last;
  logic                   do_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  // Reference model: running band sum, band counter, and the pending output slot.
  longint m_acc = 0;
  int     m_band = 0;
  bit     m_hold = 0;
  longint m_data = 0;
  int     m_oband = 0;
  bit     m_fl = 0;
  int     m_hs = 0;

  mel_band_accumulator #(
    .WIDTH_IN  (W_IN),
    .Q_IN      (15),
    .ACC_WIDTH (ACCW),
    .NUM_BANDS (NB),
    .BAND_W    (BW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .di_valid      (di_valid),
    .di_data       (di_data),
    .di_last       (di_last),
    .di_ready      (di_ready),
    .do_valid      (do_valid),
    .do_data       (do_data),
    .do_band       (do_band),
    .do_frame_last (do_frame_last),
    .do_ready      (do_ready)
  );

  always #5 clock = ~clock;

  function automatic longint sat(input longint x);
`ifdef MEL_ACC_SAT_EN
    if (x > MAXV) return MAXV;
    if (x < MINV) return MINV;
    return x;
`else
    longint r;
    r = x & ((longint'(1) <<< ACCW) - 1);
    if (r > MAXV) r = r - (longint'(1) <<< ACCW);
    return r;
`endif
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("do_valid", {63'd0, do_valid}, {63'd0, m_hold});
    if (m_hold) begin
      check("do_data", $signed(do_data), m_data);
      check("do_band", {{(64-BW){1'b0}}, do_band}, m_oband);
      check("do_frame_last", {63'd0, do_frame_last}, {63'd0, m_fl});
    end
  endtask

  // One clock: apply inputs, check di_ready before the edge, update the model, check after.
  task automatic cycle(input bit v, input logic [W_IN-1:0] d, input bit l, input bit r);
    bit exp_ready;
    bit acc_now;
    longint s;
    di_valid = v; di_data = d; di_last = l; do_ready = r;
    #1;
    exp_ready = !m_hold || r;
    check("di_ready", {63'd0, di_ready}, {63'd0, exp_ready});
    acc_now = v && exp_ready;
    @(posedge clock);
    if (m_hold && r) begin
      m_hold = 0;
      m_hs++;
    end
    if (acc_now) begin
      s = sat(m_acc + longint'($signed(d)));
      if (l) begin
        m_data  = s;
        m_oband = m_band;
        m_fl    = (m_band == NB - 1);
        m_hold  = 1;
        m_acc   = 0;
        m_band  = (m_band + 1) % NB;
      end else begin
        m_acc = s;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1; di_valid = 1'b0; di_last = 1'b0; do_ready = 1'b1;
    @(posedge clock);
    m_acc = 0; m_band = 0; m_hold = 0; m_data = 0; m_oband = 0; m_fl = 0;
    #1;
    reset = 1'b0;
  endtask

  task automatic send_band(input int n, input logic [W_IN-1:0] d);
    for (int i = 0; i < n; i++) cycle(1'b1, d, i == n - 1, 1'b1);
  endtask

  initial begin
    int hs_before;
    longint stall_sum;

    // Reset state
    do_reset();
    check("rst_do_valid", {63'd0, do_valid}, 64'd0);
    check("rst_do_data", $signed(do_data), 64'sd0);
    check("rst_do_band", {{(64-BW){1'b0}}, do_band}, 64'd0);
    check("rst_frame_last", {63'd0, do_frame_last}, 64'd0);
    check("rst_di_ready", {63'd0, di_ready}, 64'd1);

    // Basic band sum: 3 x 0x3333, do_valid one cycle after the last
    cycle(1'b1, 16'h3333, 1'b0, 1'b1);
    cycle(1'b1, 16'h3333, 1'b0, 1'b1);
    check("basic_no_early_valid", {63'd0, do_valid}, 64'd0);
    cycle(1'b1, 16'h3333, 1'b1, 1'b1);
    check("basic_sum", $signed(do_data), 64'sd39321);
    check("basic_band", {{(64-BW){1'b0}}, do_band}, 64'd0);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Saturation / wrap, positive then negative full-scale
    send_band(300, 16'h7FFF);
`ifdef MEL_ACC_SAT_EN
    check("sat_pos", $signed(do_data), 64'sd8388607);
`else
    check("wrap_pos", $signed(do_data), -64'sd6947116);
`endif
    send_band(300, 16'h8000);
`ifdef MEL_ACC_SAT_EN
    check("sat_neg", $signed(do_data), -64'sd8388608);
`else
    check("wrap_neg", $signed(do_data), 64'sd6946816);
`endif
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Backpressure: band completes, downstream stalls 5 cycles while products wait
    do_reset();
    cycle(1'b1, 16'd10, 1'b0, 1'b1);
    cycle(1'b1, 16'd20, 1'b1, 1'b0);
    hs_before = m_hs;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 16'd1000, 1'b0, 1'b0);
      check("stall_di_ready", {63'd0, di_ready}, 64'd0);
      check("stall_data", $signed(do_data), 64'sd30);
    end
    cycle(1'b1, 16'd5, 1'b0, 1'b1);
    check("release_one_hs", m_hs - hs_before, 64'sd1);
    check("release_di_ready", {63'd0, di_ready}, 64'd1);
    cycle(1'b1, 16'd6, 1'b1, 1'b1);
    stall_sum = 11;
    check("after_stall_sum", $signed(do_data), stall_sum);
    check("after_stall_band", {{(64-BW){1'b0}}, do_band}, 64'd1);

    // Frame wrap: five single-sample bands -> bands 0,1,2,3,0
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b1, W_IN'(i), 1'b1, 1'b1);
      check("wrap_single_data", $signed(do_data), i);
      check("wrap_band", {{(64-BW){1'b0}}, do_band}, (i - 1) % NB);
      check("wrap_frame_last", {63'd0, do_frame_last}, {63'd0, i == NB});
    end

    // Reset mid-band discards the partial sum
    cycle(1'b1, 16'd100, 1'b0, 1'b1);
    cycle(1'b1, 16'd100, 1'b0, 1'b1);
    do_reset();
    check("midrst_valid", {63'd0, do_valid}, 64'd0);
    cycle(1'b1, 16'd7, 1'b1, 1'b1);
    check("midrst_data", $signed(do_data), 64'sd7);
    check("midrst_band", {{(64-BW){1'b0}}, do_band}, 64'd0);

    // Randomised traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), W_IN'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
